entrada_din: RTL

Input-side port of the pratica2 processor board: turns operator actions on the DE2 switches and a pushbutton into an ordered stream of data words for the processor's `din` bus. Each debounced press of the entry key captures the switch value into a small FIFO. The processor drains the FIFO through a valid/ready handshake. The block sits between the board pins (SW, KEY) and the processor's data input, in place of wiring `din` straight to the switches.

---
 rtl/entrada_din.sv | 117 +++++++++++
 1 files changed

// File: rtl/entrada_din.sv
// Switch/pushbutton entry port: debounces the active-low entry key and, on each
// press, queues the synchronized switch value for the processor's din handshake.
module entrada_din #(
    parameter int SW_W       = 8,
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 4,
    parameter int DEB_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [SW_W-1:0]            sw,
    input  logic                       key_n,
    input  logic                       clr_ovf,
    output logic [DATA_W-1:0]          din,
    output logic                       din_valid,
    input  logic                       din_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic              key_meta_reg;
    logic              k_s_reg;
    logic [SW_W-1:0]   sw_meta_reg;
    logic [SW_W-1:0]   sw_s_reg;
    logic              deb_reg;
    logic [DCNT_W-1:0] dcnt_reg;

    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;
    logic [DATA_W-1:0] mem [DEPTH];

    logic deb_done;
    logic press;
    logic pop;
    logic push;
    logic drop;

    // Two-flop synchronizers, then a level debouncer on the key.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_meta_reg <= 1'b1;
            k_s_reg      <= 1'b1;
            sw_meta_reg  <= '0;
            sw_s_reg     <= '0;
            deb_reg      <= 1'b1;
            dcnt_reg     <= '0;
        end else begin
            key_meta_reg <= key_n;
            k_s_reg      <= key_meta_reg;
            sw_meta_reg  <= sw;
            sw_s_reg     <= sw_meta_reg;
            if (k_s_reg == deb_reg) begin
                dcnt_reg <= '0;
            end else if (deb_done) begin
                deb_reg  <= k_s_reg;
                dcnt_reg <= '0;
            end else begin
                dcnt_reg <= dcnt_reg + 1'b1;
            end
        end
    end

    assign deb_done  = (dcnt_reg == DCNT_W'(DEB_CYCLES - 1));
    // Press fires on the same edge that the debounced level falls.
    assign press     = deb_reg && !k_s_reg && deb_done;

    assign din_valid = (count_reg != '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign pop       = din_valid && din_ready;
    assign push      = press && (!full || pop);
    assign drop      = press && !push;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= DATA_W'(sw_s_reg);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
            // A dropped press outranks a simultaneous clear.
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (clr_ovf) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign din      = din_valid ? mem[rd_ptr_reg] : '0;
    assign count    = count_reg;
    assign overflow = overflow_reg;

endmodule
